muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit; the sequential companion to the single-cycle ALU.

---
 rtl/muldiv_unit.sv | 142 ++++++++++++++
 tb/tb_muldiv_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one bit per cycle, valid/ready on both sides.
// Operates on magnitudes through an unsigned core and sign-corrects the result on the final step.
module muldiv_unit #(
    parameter int data_width = 32,
    parameter int op_width   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [op_width-1:0]   md_op,
    input  logic [data_width-1:0] md_din1,
    input  logic [data_width-1:0] md_din2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] md_dout
);
    localparam int W  = data_width;
    localparam int CW = $clog2(data_width);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]       cnt;
    logic [op_width-1:0] op_q;
    logic                neg_q;
    logic [W-1:0]        opnd_q;
    logic [2*W-1:0]      acc_q;

    // Accept-time decode
    logic         is_div, s1, s2, div_zero, div_ovf, special;
    logic [W-1:0] a_abs, b_abs, special_res;

    always_comb begin
        is_div   = md_op[2];
        s1       = md_din1[W-1] && (md_op == 3'd1 || md_op == 3'd2 || md_op == 3'd4 || md_op == 3'd6);
        s2       = md_din2[W-1] && (md_op == 3'd1 || md_op == 3'd4 || md_op == 3'd6);
        a_abs    = s1 ? -md_din1 : md_din1;
        b_abs    = s2 ? -md_din2 : md_din2;
        div_zero = is_div && (md_din2 == '0);
        div_ovf  = (md_op == 3'd4 || md_op == 3'd6) && (md_din1 == {1'b1, {(W-1){1'b0}}})
                   && (md_din2 == '1);
        special  = div_zero || div_ovf;
        if (div_zero)
            special_res = md_op[1] ? md_din1 : '1;
        else
            special_res = md_op[1] ? '0 : md_din1;
    end

    // Multiply: acc = {partial high, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend bits shifting into quotient}.
    logic [W:0]     mul_sum, div_shift;
    logic [W-1:0]   div_diff, div_rem, quo, rmd;
    logic           div_ge;
    logic [2*W-1:0] mul_nxt, div_nxt, prod;
    logic [W-1:0]   result;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_nxt   = {mul_sum, acc_q[W-1:1]};
        div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_diff  = div_shift[W-1:0] - opnd_q;
        div_rem   = div_ge ? div_diff : div_shift[W-1:0];
        div_nxt   = {div_rem, acc_q[W-2:0], div_ge};
        prod      = neg_q ? -mul_nxt : mul_nxt;
        quo       = neg_q ? -div_nxt[W-1:0] : div_nxt[W-1:0];
        rmd       = neg_q ? -div_nxt[2*W-1:W] : div_nxt[2*W-1:W];
        if (op_q[2])
            result = op_q[1] ? rmd : quo;
        else if (op_q == '0)
            result = prod[W-1:0];
        else
            result = prod[2*W-1:W];
    end

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (in_valid) state_nxt = special ? DONE : CALC;
                CALC: if (cnt == CW'(W-1)) state_nxt = DONE;
                DONE: if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            out_valid <= 1'b0;
            md_dout   <= '0;
        end else if (flush) begin
            cnt       <= '0;
            out_valid <= 1'b0;
            md_dout   <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_q   <= md_op;
                    neg_q  <= (md_op == 3'd6) ? s1 : (s1 ^ s2);
                    cnt    <= '0;
                    opnd_q <= is_div ? b_abs : a_abs;
                    acc_q  <= is_div ? {{W{1'b0}}, a_abs} : {{W{1'b0}}, b_abs};
                    if (special) begin
                        out_valid <= 1'b1;
                        md_dout   <= special_res;
                    end
                end
                CALC: begin
                    acc_q <= op_q[2] ? div_nxt : mul_nxt;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(W-1)) begin
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        md_dout   <= result;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    md_dout   <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit; expected results go into a queue that a monitor drains.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   md_op = '0;
    logic [W-1:0] md_din1 = '0;
    logic [W-1:0] md_din2 = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] md_dout;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];

    muldiv_unit #(.data_width(W), .op_width(3)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .md_op(md_op), .md_din1(md_din1), .md_din2(md_din2),
        .out_valid(out_valid), .out_ready(out_ready), .md_dout(md_dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a handshake edge is coming whenever out_valid && out_ready at the falling edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", {31'b0, out_valid}, 32'd0);
            end else begin
                check("result", md_dout, exp_q.pop_front());
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        wait_ready();
        md_op = op; md_din1 = a; md_din2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        md_din1 = ~a; md_din2 = a ^ b; md_op = ~op;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_lat);
        int lat = 1;
        exp_q.push_back(exp);
        issue(op, a, b);
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        check({name, "_latency"}, W'(lat), W'(exp_lat));
        lat = 0;
        while (out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    initial begin
        int seen;
        #1;
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_md_dout", md_dout, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);

        run_op("mul",     3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        run_op("mulh",    3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        run_op("mulhu",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run_op("mulhsu",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        run_op("div",     3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        run_op("rem",     3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        run_op("divu",    3'd5, 32'd100,      32'd7,        32'd14,       33);
        run_op("remu",    3'd7, 32'd100,      32'd7,        32'd2,        33);
        run_op("div_z",   3'd4, 32'd1234,     32'd0,        32'hFFFFFFFF, 1);
        run_op("remu_z",  3'd7, 32'd5,        32'd0,        32'd5,        1);
        run_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

        // Backpressure: result must hold while the consumer stalls.
        out_ready = 1'b0;
        exp_q.push_back(32'hFFFFFFFE);
        issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        seen = 0;
        while (!out_valid && seen < 200) begin
            @(posedge clk); #1; seen++;
        end
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", md_dout, 32'hFFFFFFFE);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_out_valid_drop", {31'b0, out_valid}, 32'd0);
        check("bp_idle", {31'b0, in_ready}, 32'd1);
        check("bp_dout_zero", md_dout, 32'd0);

        // Flush partway through a calculation.
        issue(3'd5, 32'd1000, 32'd3);
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_idle", {31'b0, in_ready}, 32'd1);
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);

        // Flush and in_valid together: nothing accepted.
        md_op = 3'd5; md_din1 = 32'd50; md_din2 = 32'd5;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_vs_accept", {31'b0, in_ready}, 32'd1);

        // Asynchronous reset partway through a calculation.
        issue(3'd0, 32'd12345, 32'd678);
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_md_dout", md_dout, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("no_stray_result", W'(seen), 32'd0);

        run_op("divu_after", 3'd5, 32'd9, 32'd3, 32'd3, 33);
        check("queue_drained", W'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
